// File: rtl/tf_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : tf_loader_if
//  Purpose  : Valid/ready stream carrying complex twiddle words to tf_loader.
//  Revision : 1.0  initial release
// ============================================================================

interface tf_loader_if #(
   parameter int float_len = 32
) ();

   logic [2*float_len-1:0] din;
   logic                   din_valid;
   logic                   din_ready;

   modport master (
      output din,
      output din_valid,
      input  din_ready
   );

   modport slave (
      input  din,
      input  din_valid,
      output din_ready
   );

endinterface

`default_nettype wire

// File: rtl/tf_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tf_loader
//  Purpose  : Streams tf_num twiddle words into the twiddle BRAM and flags
//             completion; TF_LOADER_VERIFY_EN adds an XOR read-back check.
//  Revision : 1.0  initial release
// ============================================================================

module tf_loader #(
   parameter int float_len        = 32,
   parameter int tf_num           = 8,
   parameter int bram_tf_addr_len = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   tf_loader_if.slave                  in_if,
   output logic                        ena,
   output logic                        wea,
   output logic [bram_tf_addr_len-1:0] addra,
   output logic [2*float_len-1:0]      dina,
`ifdef TF_LOADER_VERIFY_EN
   output logic                        enb,
   output logic [bram_tf_addr_len-1:0] addrb,
   input  logic [2*float_len-1:0]      doutb,
   output logic                        verify_ok,
`endif
   output logic                        busy,
   output logic                        load_done
);

   localparam int c_word_w = 2 * float_len;
   localparam logic [bram_tf_addr_len-1:0] c_last_addr = bram_tf_addr_len'(tf_num - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_VERIFY = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t                      state_q, state_d;
   logic [bram_tf_addr_len-1:0] cnt_q, cnt_d;
   logic [c_word_w-1:0]         wxor_q, wxor_d;
   logic                        wr_q, wr_d;
   logic [bram_tf_addr_len-1:0] addra_q, addra_d;
   logic [c_word_w-1:0]         dina_q, dina_d;
   logic                        din_ready_q, din_ready_d;
   logic                        busy_q, busy_d;
   logic                        load_done_q, load_done_d;
   logic                        accept;

`ifdef TF_LOADER_VERIFY_EN
   localparam logic [bram_tf_addr_len:0] c_rd_end = (bram_tf_addr_len + 1)'(tf_num);

   logic [bram_tf_addr_len:0]   rd_cnt_q, rd_cnt_d;
   logic                        enb_q, enb_d;
   logic [bram_tf_addr_len-1:0] addrb_q, addrb_d;
   logic                        rd_vld_q, rd_vld_d;
   logic [c_word_w-1:0]         rxor_q, rxor_d;
   logic                        verify_ok_q, verify_ok_d;
`endif

   // din_ready_q is only ever high in LOAD, so it doubles as the state qualifier
   assign accept = in_if.din_valid & din_ready_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wxor_d   = wxor_q;
      wr_d     = 1'b0;
      addra_d  = '0;
      dina_d   = '0;
`ifdef TF_LOADER_VERIFY_EN
      rd_cnt_d    = rd_cnt_q;
      enb_d       = 1'b0;
      addrb_d     = '0;
      rd_vld_d    = enb_q;
      rxor_d      = rxor_q;
      verify_ok_d = verify_ok_q;
`endif

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
               wxor_d  = '0;
`ifdef TF_LOADER_VERIFY_EN
               rd_cnt_d    = '0;
               rd_vld_d    = 1'b0;
               rxor_d      = '0;
               verify_ok_d = 1'b0;
`endif
            end
         end

         ST_LOAD: begin
            if (accept) begin
               wr_d    = 1'b1;
               addra_d = cnt_q;
               dina_d  = in_if.din;
               wxor_d  = wxor_q ^ in_if.din;
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == c_last_addr) begin
`ifdef TF_LOADER_VERIFY_EN
                  // Issue read 0 alongside the transition so it appears in the first VERIFY cycle
                  state_d  = ST_VERIFY;
                  enb_d    = 1'b1;
                  addrb_d  = '0;
                  rd_cnt_d = (bram_tf_addr_len + 1)'(1);
`else
                  state_d  = ST_DONE;
`endif
               end
            end
         end

`ifdef TF_LOADER_VERIFY_EN
         ST_VERIFY: begin
            if (rd_cnt_q != c_rd_end) begin
               enb_d    = 1'b1;
               addrb_d  = rd_cnt_q[bram_tf_addr_len-1:0];
               rd_cnt_d = rd_cnt_q + 1'b1;
            end
            if (rd_vld_q) begin
               rxor_d = rxor_q ^ doutb;
            end
            // Last read data arrives once the read port has gone quiet
            if (rd_vld_q && !enb_q) begin
               state_d     = ST_DONE;
               verify_ok_d = ((rxor_q ^ doutb) == wxor_q);
            end
         end
`endif

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      din_ready_d = (state_d == ST_LOAD);
      busy_d      = (state_d == ST_LOAD) || (state_d == ST_VERIFY);
      load_done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         wxor_q      <= '0;
         wr_q        <= 1'b0;
         addra_q     <= '0;
         dina_q      <= '0;
         din_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         load_done_q <= 1'b0;
`ifdef TF_LOADER_VERIFY_EN
         rd_cnt_q    <= '0;
         enb_q       <= 1'b0;
         addrb_q     <= '0;
         rd_vld_q    <= 1'b0;
         rxor_q      <= '0;
         verify_ok_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wxor_q      <= wxor_d;
         wr_q        <= wr_d;
         addra_q     <= addra_d;
         dina_q      <= dina_d;
         din_ready_q <= din_ready_d;
         busy_q      <= busy_d;
         load_done_q <= load_done_d;
`ifdef TF_LOADER_VERIFY_EN
         rd_cnt_q    <= rd_cnt_d;
         enb_q       <= enb_d;
         addrb_q     <= addrb_d;
         rd_vld_q    <= rd_vld_d;
         rxor_q      <= rxor_d;
         verify_ok_q <= verify_ok_d;
`endif
      end
   end

   assign in_if.din_ready = din_ready_q;
   assign ena             = wr_q;
   assign wea             = wr_q;
   assign addra           = addra_q;
   assign dina            = dina_q;
   assign busy            = busy_q;
   assign load_done       = load_done_q;
`ifdef TF_LOADER_VERIFY_EN
   assign enb             = enb_q;
   assign addrb           = addrb_q;
   assign verify_ok       = verify_ok_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tf_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tf_loader
//  Purpose  : Directed self-checking bench for tf_loader with a BRAM model.
//  Revision : 1.0  initial release
// ============================================================================

module tb_tf_loader;

   localparam int c_fl  = 32;
   localparam int c_num = 8;
   localparam int c_aw  = 3;
   localparam int c_w   = 2 * c_fl;

   logic            clk   = 1'b0;
   logic            rst   = 1'b1;
   logic            start = 1'b0;
   logic            ena;
   logic            wea;
   logic [c_aw-1:0] addra;
   logic [c_w-1:0]  dina;
   logic            busy;
   logic            load_done;
`ifdef TF_LOADER_VERIFY_EN
   logic            enb;
   logic [c_aw-1:0] addrb;
   logic [c_w-1:0]  doutb    = '0;
   logic            verify_ok;
   logic            corrupt5 = 1'b0;
`endif

   logic [c_w-1:0]  mem [c_num];
   logic [c_aw-1:0] wr_addr_q [$];
   logic [c_w-1:0]  wr_data_q [$];

   int n_cmp = 0;
   int n_mis = 0;

   tf_loader_if #(.float_len(c_fl)) in_if ();

   tf_loader #(
      .float_len        (c_fl),
      .tf_num           (c_num),
      .bram_tf_addr_len (c_aw)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_if     (in_if),
      .ena       (ena),
      .wea       (wea),
      .addra     (addra),
      .dina      (dina),
`ifdef TF_LOADER_VERIFY_EN
      .enb       (enb),
      .addrb     (addrb),
      .doutb     (doutb),
      .verify_ok (verify_ok),
`endif
      .busy      (busy),
      .load_done (load_done)
   );

   always #5 clk = ~clk;

   // BRAM model: write log on port A, synchronous read on port B
   always @(posedge clk) begin
      if (ena && wea) begin
         mem[addra] <= dina;
         wr_addr_q.push_back(addra);
         wr_data_q.push_back(dina);
      end
`ifdef TF_LOADER_VERIFY_EN
      if (enb) begin
         doutb <= (corrupt5 && addrb == 3'd5) ? (mem[addrb] ^ 64'd1) : mem[addrb];
      end
`endif
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_din_ready"}, 64'(in_if.din_ready), 64'd0);
      check({tag, "_ena"},       64'(ena),             64'd0);
      check({tag, "_wea"},       64'(wea),             64'd0);
      check({tag, "_addra"},     64'(addra),           64'd0);
      check({tag, "_dina"},      dina,                 64'd0);
      check({tag, "_busy"},      64'(busy),            64'd0);
      check({tag, "_load_done"}, 64'(load_done),       64'd0);
`ifdef TF_LOADER_VERIFY_EN
      check({tag, "_enb"},       64'(enb),             64'd0);
      check({tag, "_addrb"},     64'(addrb),           64'd0);
      check({tag, "_verify_ok"}, 64'(verify_ok),       64'd0);
`endif
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, output int cyc);
      cyc = 0;
      while (load_done !== 1'b1 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check(tag, 64'(load_done === 1'b1), 64'd1);
   endtask

   task automatic check_log(input string tag, input logic [63:0] base);
      @(negedge clk);
      check({tag, "_count"}, 64'(wr_addr_q.size()), 64'(c_num));
      for (int k = 0; k < c_num && k < wr_addr_q.size(); k++) begin
         check({tag, "_addr"}, 64'(wr_addr_q[k]), 64'(k));
         check({tag, "_data"}, wr_data_q[k], base + 64'(k));
         check({tag, "_mem"},  mem[k],       base + 64'(k));
      end
      wr_addr_q.delete();
      wr_data_q.delete();
   endtask

   // Back-to-back beats with per-cycle write timing checks
   task automatic load_b2b(input logic [63:0] base);
      int cyc;
      pulse_start();
      check("b2b_ready_after_start", 64'(in_if.din_ready), 64'd1);
      check("b2b_busy_after_start",  64'(busy),            64'd1);
      check("b2b_done_after_start",  64'(load_done),       64'd0);
      for (int k = 0; k <= c_num; k++) begin
         @(negedge clk);
         if (k == 0) begin
            check("b2b_no_early_write", 64'(ena), 64'd0);
         end else begin
            check("b2b_ena",   64'(ena),   64'd1);
            check("b2b_wea",   64'(wea),   64'd1);
            check("b2b_addra", 64'(addra), 64'(k - 1));
            check("b2b_dina",  dina,       base + 64'(k - 1));
         end
         if (k < c_num) begin
            in_if.din       = base + 64'(k);
            in_if.din_valid = 1'b1;
         end else begin
            in_if.din_valid = 1'b0;
         end
      end
      check("b2b_ready_fall", 64'(in_if.din_ready), 64'd0);
`ifdef TF_LOADER_VERIFY_EN
      check("b2b_verify_busy",  64'(busy),      64'd1);
      check("b2b_verify_nodn",  64'(load_done), 64'd0);
      check("b2b_verify_enb",   64'(enb),       64'd1);
      check("b2b_verify_addrb", 64'(addrb),     64'd0);
      wait_done("b2b_verify_done", cyc);
      check("b2b_verify_cycles", 64'(cyc), 64'd9);
`else
      check("b2b_load_done", 64'(load_done), 64'd1);
      check("b2b_busy_fall", 64'(busy),      64'd0);
      cyc = 0;
`endif
   endtask

   // din_valid toggles every cycle; a stray start pulse lands mid-load
   task automatic load_toggle(input logic [63:0] base);
      int cyc;
      pulse_start();
      check("tgl_done_drops", 64'(load_done), 64'd0);
`ifdef TF_LOADER_VERIFY_EN
      check("tgl_vok_cleared", 64'(verify_ok), 64'd0);
`endif
      for (int i = 0; i < 2 * c_num; i++) begin
         @(negedge clk);
         in_if.din_valid = (i % 2 == 0);
         in_if.din       = base + 64'(i / 2);
         start           = (i == 5);
      end
      @(negedge clk);
      in_if.din_valid = 1'b0;
      start           = 1'b0;
      wait_done("tgl_done", cyc);
   endtask

   initial begin
      in_if.din       = '0;
      in_if.din_valid = 1'b0;

      #2 rst = 1'b0;
      #10;
      check_zero("por");

      // valid data in IDLE must be ignored
      @(negedge clk);
      rst             = 1'b1;
      in_if.din_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("idle_ready", 64'(in_if.din_ready), 64'd0);
      end
      in_if.din_valid = 1'b0;
      check("idle_no_writes", 64'(wr_addr_q.size()), 64'd0);

      // asynchronous reset after three beats
      pulse_start();
      for (int k = 0; k < 3; k++) begin
         in_if.din       = 64'h1111_0000_0000_0000 + 64'(k);
         in_if.din_valid = 1'b1;
         @(negedge clk);
      end
      in_if.din_valid = 1'b0;
      check("partial_ena",    64'(ena),               64'd1);
      check("partial_writes", 64'(wr_addr_q.size()),  64'd2);
      #2 rst = 1'b0;
      #1 check_zero("mid_reset");
      @(negedge clk);
      rst             = 1'b1;
      in_if.din_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("post_reset_ready", 64'(in_if.din_ready), 64'd0);
      end
      in_if.din_valid = 1'b0;
      wr_addr_q.delete();
      wr_data_q.delete();

      load_b2b(64'h3F80_0000_0000_0000);
      check_log("load_a", 64'h3F80_0000_0000_0000);
`ifdef TF_LOADER_VERIFY_EN
      check("load_a_vok", 64'(verify_ok), 64'd1);
`endif

      // valid data in DONE must be ignored
      in_if.din_valid = 1'b1;
      in_if.din       = 64'hDEAD_BEEF_DEAD_BEEF;
      repeat (3) begin
         @(negedge clk);
         check("done_hold", 64'(load_done), 64'd1);
         check("done_ena",  64'(ena),       64'd0);
      end
      in_if.din_valid = 1'b0;
      check("done_no_writes", 64'(wr_addr_q.size()), 64'd0);

      load_toggle(64'h4000_0000_BF80_0000);
      check_log("load_b", 64'h4000_0000_BF80_0000);
`ifdef TF_LOADER_VERIFY_EN
      check("load_b_vok", 64'(verify_ok), 64'd1);

      corrupt5 = 1'b1;
      load_b2b(64'h3F00_0000_0000_0010);
      check("corrupt_vok",  64'(verify_ok), 64'd0);
      check("corrupt_done", 64'(load_done), 64'd1);
      corrupt5 = 1'b0;
      check_log("load_c", 64'h3F00_0000_0000_0010);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

`default_nettype wire
